// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble deserializer.
// PARITY_CHECK_EN adds a parity-bit state and widens each FIFO entry by an error flag.
package nibble_pkg;

    localparam int unsigned WORD_W = 4;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

`ifdef PARITY_CHECK_EN
    localparam int unsigned ENTRY_W = WORD_W + 1;
    typedef enum logic [0:0] {StCollect, StParity} state_e;
`else
    localparam int unsigned ENTRY_W = WORD_W;
    typedef enum logic [0:0] {StCollect} state_e;
`endif

    function automatic logic [WORD_W-1:0] shift_in(
        input logic [WORD_W-1:0] sr,
        input logic              din,
        input logic              dir
    );
        logic [WORD_W-1:0] res;
        if (dir == DIR_LSB_FIRST) begin
            res = {din, sr[WORD_W-1:1]};
        end else begin
            res = {sr[WORD_W-2:0], din};
        end
        return res;
    endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Small synchronous FIFO; pointers carry one extra bit to tell full from empty.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module nibble_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic             dropped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = pop && !empty && !clear;
        do_push = push && !clear && (!full || do_pop);
        dropped = push && !clear && full && !do_pop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage is not reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/nibble_deserializer.sv
// Assembles 4-bit words from a gapped serial stream into an output FIFO.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit and expose parity_err.
module nibble_deserializer
    import nibble_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              serial_valid,
    input  logic              serial_in,
    input  logic              shift_dir,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
`ifdef PARITY_CHECK_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    state_e            state_q;
    logic [1:0]        bit_cnt_q;
    logic              dir_q;
    logic [WORD_W-1:0] sr_q;
    logic              overrun_q;

    logic              first_bit;
    logic              eff_dir;
    logic [WORD_W-1:0] sr_next;
    logic              take;
    logic              push;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_dropped;
    logic              pop;

    // The first bit of a word uses the live direction; later bits use the latched one.
    always_comb begin
        first_bit = (state_q == StCollect) && (bit_cnt_q == 2'd0);
        eff_dir   = first_bit ? shift_dir : dir_q;
        sr_next   = shift_in(sr_q, serial_in, eff_dir);
        take      = serial_valid && !clear;
`ifdef PARITY_CHECK_EN
        push      = take && (state_q == StParity);
        push_data = {serial_in ^ (^sr_q), sr_q};
`else
        push      = take && (state_q == StCollect) && (bit_cnt_q == 2'd3);
        push_data = sr_next;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StCollect;
            bit_cnt_q <= 2'd0;
            dir_q     <= DIR_MSB_FIRST;
            sr_q      <= '0;
        end else if (clear) begin
            state_q   <= StCollect;
            bit_cnt_q <= 2'd0;
        end else if (serial_valid) begin
            case (state_q)
                StCollect: begin
                    sr_q      <= sr_next;
                    bit_cnt_q <= bit_cnt_q + 2'd1;
                    if (first_bit) begin
                        dir_q <= shift_dir;
                    end
`ifdef PARITY_CHECK_EN
                    if (bit_cnt_q == 2'd3) begin
                        state_q <= StParity;
                    end
`endif
                end
`ifdef PARITY_CHECK_EN
                StParity: begin
                    state_q <= StCollect;
                end
`endif
                default: begin
                    state_q   <= StCollect;
                    bit_cnt_q <= 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (clear) begin
            overrun_q <= 1'b0;
        end else if (fifo_dropped) begin
            overrun_q <= 1'b1;
        end
    end

    assign pop = out_valid && out_ready;

    nibble_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .dropped   (fifo_dropped)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head[WORD_W-1:0];
    assign overrun   = overrun_q;
`ifdef PARITY_CHECK_EN
    assign parity_err = head[WORD_W];
    assign busy       = (bit_cnt_q != 2'd0) || (state_q == StParity);
`else
    assign busy       = (bit_cnt_q != 2'd0);
`endif

endmodule

// File: tb/tb_nibble_deserializer.sv
// Directed and randomized bench for nibble_deserializer against a queue-based word model.
// Follows PARITY_CHECK_EN the same way the design does.
module tb_nibble_deserializer;

    localparam int unsigned DEPTH = 2;
`ifdef PARITY_CHECK_EN
    localparam int NBITS = 5;
`else
    localparam int NBITS = 4;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       serial_valid = 1'b0;
    logic       serial_in = 1'b0;
    logic       shift_dir = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       out_valid;
    logic       overrun;
    logic       busy;
`ifdef PARITY_CHECK_EN
    logic       parity_err;
`endif

    int tests = 0;
    int fails = 0;

    // Model: queue of {err, word}, collected bits of the word in flight, sticky overrun.
    logic [4:0] mq[$];
    logic       mb[5];
    int         mcnt = 0;
    logic       mdir = 1'b0;
    logic       movr = 1'b0;

    always #5 clock = ~clock;

    nibble_deserializer #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .clear        (clear),
        .serial_valid (serial_valid),
        .serial_in    (serial_in),
        .shift_dir    (shift_dir),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
`ifdef PARITY_CHECK_EN
        .parity_err   (parity_err),
`endif
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_entry();
        logic [3:0] w;
        logic       err;
        w = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (mdir) w[i] = mb[i];
            else      w[3-i] = mb[i];
        end
        err = 1'b0;
`ifdef PARITY_CHECK_EN
        err = (mb[4] != ^w);
`endif
        return {err, w};
    endfunction

    task automatic check_outputs(input string tag);
        logic [4:0] head;
        head = (mq.size() != 0) ? mq[0] : 5'h00;
        check({tag, ".out_valid"}, out_valid, mq.size() != 0);
        check({tag, ".out_data"}, out_data, head[3:0]);
        check({tag, ".overrun"}, overrun, movr);
        check({tag, ".busy"}, busy, mcnt != 0);
`ifdef PARITY_CHECK_EN
        check({tag, ".parity_err"}, parity_err, head[4]);
`endif
    endtask

    task automatic step(input logic sv, input logic sin, input logic dir, input logic rdy,
                        input logic clr);
        serial_valid = sv;
        serial_in    = sin;
        shift_dir    = dir;
        out_ready    = rdy;
        clear        = clr;
        if (clr) begin
            mq.delete();
            mcnt = 0;
            movr = 1'b0;
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (sv) begin
                if (mcnt == 0) mdir = dir;
                mb[mcnt] = sin;
                mcnt++;
                if (mcnt == NBITS) begin
                    mcnt = 0;
                    if (mq.size() < DEPTH) mq.push_back(model_entry());
                    else movr = 1'b1;
                end
            end
        end
        @(posedge clock);
        #1;
        check_outputs("step");
    endtask

    task automatic do_reset(input int hold);
        serial_valid = 1'b0;
        clear        = 1'b0;
        out_ready    = 1'b0;
        reset        = 1'b1;
        mq.delete();
        mcnt = 0;
        movr = 1'b0;
        #2;
        check_outputs("reset_async");
        repeat (hold) @(posedge clock);
        #1;
        check_outputs("reset_hold");
        reset = 1'b0;
    endtask

    // Sends one word (plus parity bit when enabled); gap idle cycles scramble serial_in/shift_dir.
    task automatic send_word(input logic [3:0] w, input logic dir, input logic rdy,
                             input logic last_rdy, input int gap, input logic par_ok);
        logic b;
        for (int i = 0; i < 4; i++) begin
            b = dir ? w[i] : w[3-i];
            step(1'b1, b, dir, (i == 3 && NBITS == 4) ? last_rdy : rdy, 1'b0);
            if (i < NBITS - 1) begin
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 1'($urandom), 1'($urandom), rdy, 1'b0);
                end
            end
        end
`ifdef PARITY_CHECK_EN
        step(1'b1, par_ok ? ^w : ~^w, dir, last_rdy, 1'b0);
`else
        b = par_ok;
`endif
    endtask

    initial begin
        #1;
        do_reset(2);

        // LSB-first, back-to-back bits
        send_word(4'hD, 1'b1, 1'b1, 1'b1, 0, 1'b1);
        check("lsb_valid", out_valid, 1'b1);
        check("lsb_data", out_data, 4'hD);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("lsb_one_cycle", out_valid, 1'b0);

        // MSB-first with gaps
        send_word(4'hB, 1'b0, 1'b1, 1'b1, 3, 1'b1);
        check("msb_gap_data", out_data, 4'hB);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun with stalled consumer
        send_word(4'h1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        send_word(4'h2, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        send_word(4'h3, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_head1", out_data, 4'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovr_head2", out_data, 4'h2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovr_drained", out_valid, 1'b0);
        check("ovr_sticky", overrun, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_cleared", overrun, 1'b0);

        // Reset mid-word leaves no residue
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        do_reset(1);
        send_word(4'h1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
        check("rst_mid_data", out_data, 4'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Direction change after the first bit is ignored
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef PARITY_CHECK_EN
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
        check("dir_latched", out_data, 4'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Full FIFO, final bit coincides with a pop
        send_word(4'hA, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        send_word(4'h5, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        send_word(4'hC, 1'b1, 1'b0, 1'b1, 0, 1'b1);
        check("full_pop_ovr", overrun, 1'b0);
        check("full_pop_head", out_data, 4'h5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full_pop_next", out_data, 4'hC);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full_pop_empty", out_valid, 1'b0);

        // Clear drops a partial word and the bit presented with it
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("clear_busy", busy, 1'b0);

`ifdef PARITY_CHECK_EN
        send_word(4'h7, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        check("par_bad", parity_err, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'h7, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        check("par_good", parity_err, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 2) != 0, 1'($urandom), 1'($urandom),
                 (n % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 59) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
